// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter sharing one UART transmitter with busy timeout and guard time
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int IDW          = 2,
    parameter int DATA_W       = 8,
    parameter int OS_RATE      = 16,
    parameter int GUARD_BITS   = 2,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      os_tick,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IDW-1:0]            owner,
    output logic                      owner_valid,
    output logic                      err_timeout
);

    localparam int GUARD_LEN = GUARD_BITS * OS_RATE;
    localparam int GW        = $clog2(GUARD_LEN) + 1;
    localparam int TW        = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GUARD} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [GW-1:0]   guard_cnt;
    logic [TW-1:0]   to_cnt;

    logic [DATA_W-1:0] data_arr [N_REQ];
    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    scan_idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_data
        assign data_arr[i] = data[i*DATA_W +: DATA_W];
    end

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = rr_ptr;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = (scan_idx == IDW'(N_REQ-1)) ? '0 : scan_idx + IDW'(1);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            rr_ptr      <= IDW'(N_REQ-1);
            guard_cnt   <= '0;
            to_cnt      <= '0;
            gnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            gnt         <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt         <= N_REQ'(1) << win_idx;
                        tx_start    <= 1'b1;
                        tx_data     <= data_arr[win_idx];
                        owner       <= win_idx;
                        owner_valid <= 1'b1;
                        rr_ptr      <= win_idx;
                        to_cnt      <= '0;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TW'(BUSY_TIMEOUT-1)) begin
                        err_timeout <= 1'b1;
                        // A transmitter that never answered still gets the guard gap.
                        if (GUARD_LEN == 0) begin
                            state       <= IDLE;
                            owner_valid <= 1'b0;
                        end else begin
                            state     <= GUARD;
                            guard_cnt <= GW'(GUARD_LEN);
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (GUARD_LEN == 0) begin
                            state       <= IDLE;
                            owner_valid <= 1'b0;
                        end else begin
                            state     <= GUARD;
                            guard_cnt <= GW'(GUARD_LEN);
                        end
                    end
                end
                GUARD: begin
                    if (os_tick) begin
                        if (guard_cnt == GW'(1)) begin
                            state       <= IDLE;
                            owner_valid <= 1'b0;
                        end else begin
                            guard_cnt <= guard_cnt - GW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int N      = 4;
    localparam int GTICKS = 32;
    localparam int BTO    = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        os_tick = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic        tx_busy = 1'b0;
    logic [3:0]  gnt;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  owner;
    logic        owner_valid;
    logic        err_timeout;

    logic [3:0]  req_z = '0;
    logic [31:0] data_z = '0;
    logic        tx_busy_z = 1'b0;
    logic [3:0]  gnt_z;
    logic        tx_start_z;
    logic [7:0]  tx_data_z;
    logic [1:0]  owner_z;
    logic        owner_valid_z;
    logic        err_timeout_z;

    uart_tx_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .req(req), .data(data),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .owner(owner), .owner_valid(owner_valid), .err_timeout(err_timeout)
    );

    uart_tx_scheduler #(.GUARD_BITS(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .req(req_z), .data(data_z),
        .gnt(gnt_z), .tx_start(tx_start_z), .tx_data(tx_data_z), .tx_busy(tx_busy_z),
        .owner(owner_z), .owner_valid(owner_valid_z), .err_timeout(err_timeout_z)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // os_tick every third clock
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            os_tick = (c % 3 == 0);
        end
    end

    // Transmitter stand-in: raises busy in the tx_start cycle for busy_len cycles
    bit auto_xmit = 1'b0;
    int busy_len  = 5;
    initial begin
        forever begin
            @(negedge clk);
            if (auto_xmit && tx_start) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Reference model: owner slot, busy handshake, guard tick budget
    int         m_ptr, m_wait, m_guard;
    bit         m_ov, m_seen;
    logic [3:0] e_gnt;
    logic       e_start, e_err;
    logic [7:0] e_data;
    logic [1:0] e_owner;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_ptr = N - 1; m_wait = 0; m_guard = 0; m_ov = 0; m_seen = 0;
            e_gnt = '0; e_start = 0; e_err = 0; e_data = '0; e_owner = '0;
        end else begin
            bit found;
            found = 0;
            e_gnt = '0; e_start = 0; e_err = 0;
            if (m_guard > 0) begin
                if (os_tick) begin
                    m_guard--;
                    if (m_guard == 0) m_ov = 0;
                end
            end else if (m_ov && !m_seen) begin
                if (tx_busy) m_seen = 1;
                else begin
                    m_wait++;
                    if (m_wait == BTO) begin
                        e_err = 1;
                        m_guard = GTICKS;
                    end
                end
            end else if (m_ov && m_seen) begin
                if (!tx_busy) m_guard = GTICKS;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int w;
                    w = (m_ptr + k) % N;
                    if (!found && req[w[1:0]]) begin
                        found   = 1;
                        e_gnt   = 4'(1 << w);
                        e_start = 1;
                        e_data  = 8'(data >> (8 * w));
                        e_owner = 2'(w);
                        m_ptr   = w;
                        m_ov    = 1;
                        m_seen  = 0;
                        m_wait  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("tx_start", 32'(tx_start), 32'(e_start));
            check("tx_data", 32'(tx_data), 32'(e_data));
            check("owner", 32'(owner), 32'(e_owner));
            check("owner_valid", 32'(owner_valid), 32'(m_ov));
            check("err_timeout", 32'(err_timeout), 32'(e_err));
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        end
    end

    int gq[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_owner"}, 32'(owner), 0);
        check({tag, "_owner_valid"}, 32'(owner_valid), 0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_start) begin ok = 1; break; end
        end
        check({name, "_start_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!owner_valid && !tx_busy) begin ok = 1; break; end
        end
        check({name, "_idle_reached"}, 32'(ok), 1);
    endtask

    task automatic wait_grants(input string name, input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (gq.size() >= n) begin ok = 1; break; end
        end
        check({name, "_grants_seen"}, 32'(ok), 1);
    endtask

    initial begin
        int ticks, cnt;
        int exp2[5];
        bit ok;
        exp2 = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b0;

        // single request, guard measured in os_ticks after busy falls
        auto_xmit = 1; busy_len = 10;
        @(negedge clk);
        data = 32'h000000A5; req = 4'b0001;
        check("t1_gnt_before", 32'(gnt), 0);
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_tx_start", 32'(tx_start), 1);
        check("t1_tx_data", 32'(tx_data), 32'hA5);
        check("t1_owner_valid", 32'(owner_valid), 1);
        req = 4'b0000;
        @(negedge clk);
        check("t1_gnt_single", 32'(gnt), 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (!tx_busy) begin ok = 1; break; end
        end
        check("t1_busy_fell", 32'(ok), 1);
        @(posedge clk);
        ticks = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            ticks += int'(os_tick);
            #1;
            if (!owner_valid) break;
        end
        check("t1_guard_ticks", 32'(ticks), 32);

        // all requesting: strict rotation from reset pointer
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); rst_n = 1'b0;
        busy_len = 4;
        gq.delete();
        data = 32'h44332211; req = 4'b1111;
        wait_grants("t2", 5);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 32'(gq[i]), 32'(exp2[i]));
        wait_idle("t2");

        // wrap from pointer 2 skips requester 3
        data = 32'hDDCCBBAA; req = 4'b0100;
        wait_start("t3a");
        req = 4'b0000;
        wait_idle("t3a");
        gq.delete();
        req = 4'b0101;
        wait_grants("t3", 2);
        req = 4'b0000;
        check("t3_first", 32'(gq[0]), 0);
        check("t3_second", 32'(gq[1]), 2);
        wait_idle("t3");

        // transmitter never goes busy
        auto_xmit = 0;
        req = 4'b0010;
        wait_start("t4");
        req = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (err_timeout) break;
        end
        check("t4_timeout_cycles", 32'(cnt), 32);
        wait_idle("t4");
        auto_xmit = 1;
        req = 4'b1000;
        wait_start("t4b");
        check("t4b_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        wait_idle("t4b");

        // reset while transmitter busy
        busy_len = 20;
        req = 4'b0001;
        wait_start("t5a");
        req = 4'b0000;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check_all_zero("rst_wait_done");
        @(negedge clk); rst_n = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!tx_busy) begin ok = 1; break; end
        end
        check("t5_busy_clear", 32'(ok), 1);

        // reset during guard
        busy_len = 3;
        req = 4'b0001;
        wait_start("t5b");
        req = 4'b0000;
        repeat (12) @(negedge clk);
        check("t5b_in_guard", 32'(owner_valid), 1);
        #2 rst_n = 1'b1;
        #1 check_all_zero("rst_guard");
        @(negedge clk); rst_n = 1'b0;
        req = 4'b1000;
        wait_start("t5c");
        check("t5c_gnt", 32'(gnt), 32'h8);
        check("t5c_owner", 32'(owner), 3);
        req = 4'b0000;
        wait_idle("t5c");

        // no-guard build: relaunch right after busy falls
        data_z = 32'h00000077; req_z = 4'b0001;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start_z) begin ok = 1; break; end
        end
        check("t6_start_seen", 32'(ok), 1);
        for (int f = 0; f < 2; f++) begin
            tx_busy_z = 1'b1;
            repeat (4) @(negedge clk);
            tx_busy_z = 1'b0;
            @(negedge clk);
            check($sformatf("t6_gap_start%0d", f), 32'(tx_start_z), 0);
            check($sformatf("t6_gap_ov%0d", f), 32'(owner_valid_z), 0);
            @(negedge clk);
            check($sformatf("t6_restart%0d", f), 32'(tx_start_z), 1);
            check($sformatf("t6_gnt%0d", f), 32'(gnt_z), 32'h1);
            check($sformatf("t6_data%0d", f), 32'(tx_data_z), 32'h77);
        end
        req_z = 4'b0000;
        tx_busy_z = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy_z = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_idle_ov", 32'(owner_valid_z), 0);
        check("t6_no_err", 32'(err_timeout_z), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter among N_REQ byte requesters. It grants one requester at a time and launches a frame on the shared transmitter. It tracks the transmitter's busy flag, then enforces an inter-frame guard time counted in 16x-oversample ticks from the baud generator. It sits between client blocks and the shared TX serializer, timed by the same clk/os_tick domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDW, 2, width of owner index; must satisfy 2^IDW >= N_REQ
DATA_W, 8, frame payload width
OS_RATE, 16, os_tick pulses per bit period
GUARD_BITS, 2, idle bit periods between frames (0 = no guard)
BUSY_TIMEOUT, 32, clk cycles allowed for tx_busy to rise after tx_start

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high (despite name)
os_tick  in  1  single-clk pulse at 16x baud rate
req  in  N_REQ  per-requester request, level
data  in  N_REQ*DATA_W  requester i payload at bits [i*DATA_W +: DATA_W]
gnt  out  N_REQ  one-hot, single-cycle accept pulse
tx_start  out  1  single-cycle launch strobe to transmitter
tx_data  out  DATA_W  payload to transmitter, stable from tx_start until next launch
tx_busy  in  1  transmitter busy, high for the whole frame
owner  out  IDW  index of current/last granted requester
owner_valid  out  1  high from grant until guard completes
err_timeout  out  1  single-cycle pulse when tx_busy never rose

Behaviour:
- Clock and reset: clk is the clock. rst_n is the reset, asynchronous, active-high. All state updates on the posedge of clk.
- All outputs are registered.
- Reset values: gnt=0, tx_start=0, tx_data=0, owner=0, owner_valid=0, err_timeout=0, state=IDLE, rr_ptr=N_REQ-1, guard_cnt=0, to_cnt=0.
- Reset mid-frame: tx_start and gnt drop immediately; the in-flight frame is abandoned with no retry.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE, |req=1:
  - Winner is the first set req scanning from (rr_ptr+1) mod N_REQ upward with wrap.
  - On the edge: gnt[w]<=1, tx_start<=1, tx_data<=data[w], owner<=w, owner_valid<=1, rr_ptr<=w, to_cnt<=0; go to WAIT_BUSY.
  - Latency: req seen at cycle k gives gnt/tx_start high in cycle k+1 only.
- IDLE, req=0: stay.
- Requests are sampled only in IDLE. A req dropped before its gnt is never served.
- Requester contract:
  - Hold data stable while req is high.
  - After gnt, deassert req or present the next byte.
  - A req still high after gnt counts as a new request, served in rotation order.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise to_cnt increments. At to_cnt==BUSY_TIMEOUT-1: err_timeout pulses 1 cycle, go to GUARD.
  - tx_busy sampled high in the same cycle as tx_start counts as seen.
- WAIT_DONE: on tx_busy=0, go to GUARD with guard_cnt<=GUARD_BITS*OS_RATE. If GUARD_BITS=0, go straight to IDLE and clear owner_valid.
- GUARD:
  - guard_cnt decrements by 1 only on cycles with os_tick=1.
  - When guard_cnt==1 and os_tick=1: go to IDLE, clear owner_valid.
  - Guard length is therefore exactly GUARD_BITS*OS_RATE ticks.
  - os_tick outside GUARD is ignored.
- Arbitration is starvation-free: with all req high, grants cycle 0,1,2,3,0,...
- gnt is zero or one-hot at all times. tx_start never fires unless in IDLE the cycle before.
- Width rule: guard_cnt is wide enough for GUARD_BITS*OS_RATE (clog2 + 1). to_cnt is clog2(BUSY_TIMEOUT)+1 bits.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5 → gnt=0001 and tx_start one cycle later, tx_data=A5. With tx_busy high 10 cycles then low, owner_valid drops exactly 32 os_ticks after busy falls.
- req=4'b1111 held, model transmitter responding → grant order 0,1,2,3,0; no gnt while owner_valid=1.
- After owner=2 completes, req=4'b0101 → next grant is 0 (wrap from ptr=2 skips index 3), then 2.
- tx_busy tied 0 after tx_start → err_timeout pulses exactly 32 cycles after tx_start; GUARD runs; next request is served normally.
- rst_n asserted during WAIT_DONE and during GUARD → all outputs 0 asynchronously. After release, req=4'b1000 is granted index 3 (rr_ptr=3, scan starts at 0, only req[3] set).
- GUARD_BITS=0 build, back-to-back req on one requester → new tx_start 1 cycle after tx_busy falls; os_tick ignored.
